axis_spi_reg_arbiter: RTL and testbench
=======================================

Name: axis_spi_reg_arbiter

Overview:
Shares one axis_spi_master byte engine between two register-access requesters. Each request is one SPI register transaction of three bytes: [rw, addr[14:8]], addr[7:0], data. The block arbitrates round-robin, serialises the bytes onto the master's Tx stream, and consumes the matching Rx bytes. It returns read data, or a timeout error, to the requester that was granted.

Parameters:
TIMEOUT, 1024, aclk cycles allowed between a Tx byte handshake and its Rx byte before abort (>=2)
GAP_CYCLES, 8, idle aclk cycles inserted after every transaction so the SPI master deasserts SS (>=1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted
req0_rw  in  1  1=read, 0=write
req0_addr  in  15  register address
req0_wdata  in  8  write data (ignored for reads)
rsp0_valid  out  1  one-cycle response strobe to requester 0
rsp0_rdata  out  8  read data (0x00 for writes/errors)
rsp0_err  out  1  timeout flag, qualified by rsp0_valid
req1_* / rsp1_*  same as requester 0, for requester 1
m_axis_tdata  out  8  Tx byte to SPI master s_axis_tdata
m_axis_tvalid  out  1  Tx valid
m_axis_tready  in  1  Tx ready
s_axis_tdata  in  8  Rx byte from SPI master m_axis_tdata
s_axis_tvalid  in  1  Rx valid
s_axis_tready  out  1  Rx ready
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; byte index 0; round-robin pointer = requester 0 preferred; timer 0.
- IDLE: if any reqN_valid, grant by priority pointer. Assert reqN_ready for exactly that cycle and latch rw/addr/wdata. Pointer moves to the other requester. If only one requester is valid, it wins regardless of the pointer. Go to SEND with index 0.
- SEND: m_axis_tvalid=1 with byte[index]:
  - byte0 = {rw, addr[14:8]}
  - byte1 = addr[7:0]
  - byte2 = wdata for writes, 0x00 for reads
  - tdata stays stable until the handshake. On handshake, clear the timer and go to WAIT_RX.
- WAIT_RX: s_axis_tready=1 (tready is 0 in every other state). On the Rx handshake:
  - index 2: capture rdata (reads) or 0x00 (writes), then go to RESP.
  - otherwise: discard the byte, increment index, return to SEND.
- Timeout: the timer increments each WAIT_RX cycle without an Rx handshake. When it reaches TIMEOUT-1, go to RESP with err=1 and rdata=0x00. Remaining bytes are not sent. An Rx handshake in the same cycle as the expiry wins (no error).
- RESP: rspN_valid=1 for one cycle to the granted requester only, with rdata/err. Go to GAP.
- GAP: hold for GAP_CYCLES cycles with m_axis_tvalid=0, then go to IDLE.
- Exactly one byte is in flight at a time, so the SPI master never holds a gap-free stream across transactions.
- Minimum latency from reqN_ready to rspN_valid, with zero-wait SPI: 6 cycles (3 x SEND + 3 x WAIT_RX), then RESP.
- Stray Rx bytes outside WAIT_RX are not accepted; they stall the master until the next WAIT_RX. The bench must never generate them.
- Reset mid-transaction: returns to IDLE immediately. m_axis_tvalid drops even though AXIS forbids it; the SPI master shares the same reset.
- reqN_valid may drop without an accept (no error). Requests are never queued; the outputs of the non-granted requester stay 0.

Decomposition:
- Package axis_spi_pkg: state encoding constants (IDLE, SEND, WAIT_RX, RESP, GAP), the byte-index width, and a function that builds the header byte {rw, addr_hi}.
- One natural sub-module: axis_spi_rr_arb2 (2-way round-robin grant with pointer register). Everything else stays in the top module.

Test Plan:
- Write req0 addr=0x1234 wdata=0xA5, zero-wait loopback -> Tx bytes 0x12, 0x34, 0xA5; rsp0_valid one cycle, err=0, rdata=0x00; busy falls after GAP_CYCLES.
- Read req1 addr=0x7F01, Rx model returns 0x11, 0x22, 0xC3 -> Tx bytes 0xFF, 0x01, 0x00; rsp1_rdata=0xC3, err=0; rsp0_valid stays 0.
- Both requesters valid continuously for 4 transactions -> grants alternate 0, 1, 0, 1; each req ready pulses once per grant.
- Rx model withholds the 2nd Rx byte -> rsp_valid with err=1, rdata=0x00 exactly TIMEOUT cycles after the 2nd Tx handshake; byte2 is never sent.
- Random m_axis_tready/s_axis_tvalid backpressure -> tdata stable while valid and not ready; byte order and responses match the write/read cases.
- aresetn asserted while in WAIT_RX of byte1 -> all outputs 0 next cycle; a new req0 after release completes normally.

Source files
------------

// File: rtl/axis_spi_pkg.sv
// Shared constants and helpers for the SPI register-access arbiter.
package axis_spi_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SEND    = 3'd1;
   localparam logic [2:0] ST_WAIT_RX = 3'd2;
   localparam logic [2:0] ST_RESP    = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;

   localparam int IDX_W = 2;

   // First byte on the wire: read flag followed by the upper address bits.
   function automatic logic [7:0] hdr_byte(input logic rw, input logic [6:0] addr_hi);
      return {rw, addr_hi};
   endfunction

endpackage

// File: rtl/axis_spi_reg_arbiter_if.sv
// Request/response ports of both requesters plus the Tx/Rx streams to the SPI byte engine.
// slave = the arbiter's view, master = the requesters and SPI master side.
interface axis_spi_reg_arbiter_if;
   logic        req0_valid, req0_ready, req0_rw;
   logic [14:0] req0_addr;
   logic [7:0]  req0_wdata;
   logic        rsp0_valid, rsp0_err;
   logic [7:0]  rsp0_rdata;
   logic        req1_valid, req1_ready, req1_rw;
   logic [14:0] req1_addr;
   logic [7:0]  req1_wdata;
   logic        rsp1_valid, rsp1_err;
   logic [7:0]  rsp1_rdata;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid, s_axis_tready;
   logic        busy;

   modport slave (
      input  req0_valid, req0_rw, req0_addr, req0_wdata,
      input  req1_valid, req1_rw, req1_addr, req1_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
      output m_axis_tdata, m_axis_tvalid, input m_axis_tready,
      input  s_axis_tdata, s_axis_tvalid, output s_axis_tready,
      output busy
   );

   modport master (
      output req0_valid, req0_rw, req0_addr, req0_wdata,
      output req1_valid, req1_rw, req1_addr, req1_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
      input  m_axis_tdata, m_axis_tvalid, output m_axis_tready,
      output s_axis_tdata, s_axis_tvalid, input s_axis_tready,
      input  busy
   );
endinterface

// File: rtl/axis_spi_rr_arb2.sv
// Two-way round-robin grant; the pointer flips to the loser on every accepted grant.
module axis_spi_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_accept,
   output logic o_gnt_valid,
   output logic o_gnt_id
);
   logic r_ptr;

   // Grant selection: pointer only matters when both requesters are valid.
   always_comb begin
      o_gnt_valid = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         o_gnt_id = r_ptr;
      end else if (i_req1) begin
         o_gnt_id = 1'b1;
      end else begin
         o_gnt_id = 1'b0;
      end
   end

   // Priority pointer update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (i_accept) begin
         r_ptr <= ~o_gnt_id;
      end
   end
endmodule

// File: rtl/axis_spi_reg_arbiter.sv
// Shares one SPI byte engine between two register requesters; each transaction is
// three bytes sent one at a time, each followed by its echoed Rx byte.
module axis_spi_reg_arbiter
   import axis_spi_pkg::*;
#(
   parameter int TIMEOUT    = 1024,
   parameter int GAP_CYCLES = 8
) (
   input logic aclk,
   input logic aresetn,
   axis_spi_reg_arbiter_if.slave bus
);
   localparam int TW = $clog2((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) + 1;

   logic [2:0]       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [TW-1:0]    r_timer;
   logic             r_gnt_id;
   logic             r_rw;
   logic [14:0]      r_addr;
   logic [7:0]       r_wdata;
   logic [7:0]       r_rdata;
   logic             r_err;

   logic       w_gnt_valid, w_gnt_id, w_accept, w_expire, w_gap_done;
   logic [7:0] w_tx_byte;

   axis_spi_rr_arb2 u_arb (
      .clk         (aclk),
      .rst         (aresetn),
      .i_req0      (bus.req0_valid),
      .i_req1      (bus.req1_valid),
      .i_accept    (w_accept),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   assign w_accept   = (r_state == ST_IDLE) && w_gnt_valid;
   // Expiry one count early so the response lands exactly TIMEOUT cycles after the Tx handshake.
   assign w_expire   = (r_timer == TW'(TIMEOUT - 2));
   assign w_gap_done = (r_timer == TW'(GAP_CYCLES - 1));

   // Byte selection for the current index.
   always_comb begin
      case (r_idx)
         2'd0:    w_tx_byte = hdr_byte(r_rw, r_addr[14:8]);
         2'd1:    w_tx_byte = r_addr[7:0];
         2'd2:    w_tx_byte = r_rw ? 8'h00 : r_wdata;
         default: w_tx_byte = 8'h00;
      endcase
   end

   // Transaction state machine; the timer doubles as the inter-transaction gap counter.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_timer  <= '0;
         r_gnt_id <= 1'b0;
         r_rw     <= 1'b0;
         r_addr   <= 15'h0000;
         r_wdata  <= 8'h00;
         r_rdata  <= 8'h00;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_gnt_id <= w_gnt_id;
                  r_rw     <= w_gnt_id ? bus.req1_rw    : bus.req0_rw;
                  r_addr   <= w_gnt_id ? bus.req1_addr  : bus.req0_addr;
                  r_wdata  <= w_gnt_id ? bus.req1_wdata : bus.req0_wdata;
                  r_idx    <= '0;
                  r_state  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (bus.m_axis_tready) begin
                  r_timer <= '0;
                  r_state <= ST_WAIT_RX;
               end
            end
            ST_WAIT_RX: begin
               if (bus.s_axis_tvalid) begin
                  if (r_idx == IDX_W'(2)) begin
                     r_rdata <= r_rw ? bus.s_axis_tdata : 8'h00;
                     r_err   <= 1'b0;
                     r_state <= ST_RESP;
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= ST_SEND;
                  end
               end else if (w_expire) begin
                  r_rdata <= 8'h00;
                  r_err   <= 1'b1;
                  r_state <= ST_RESP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            ST_RESP: begin
               r_timer <= '0;
               r_state <= ST_GAP;
            end
            ST_GAP: begin
               if (w_gap_done) begin
                  r_timer <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req0_ready    = w_accept && !w_gnt_id;
   assign bus.req1_ready    = w_accept &&  w_gnt_id;
   assign bus.rsp0_valid    = (r_state == ST_RESP) && !r_gnt_id;
   assign bus.rsp1_valid    = (r_state == ST_RESP) &&  r_gnt_id;
   assign bus.rsp0_rdata    = bus.rsp0_valid ? r_rdata : 8'h00;
   assign bus.rsp1_rdata    = bus.rsp1_valid ? r_rdata : 8'h00;
   assign bus.rsp0_err      = bus.rsp0_valid && r_err;
   assign bus.rsp1_err      = bus.rsp1_valid && r_err;
   assign bus.m_axis_tvalid = (r_state == ST_SEND);
   assign bus.m_axis_tdata  = bus.m_axis_tvalid ? w_tx_byte : 8'h00;
   assign bus.s_axis_tready = (r_state == ST_WAIT_RX);
   assign bus.busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_axis_spi_reg_arbiter.sv
// Scoreboard bench: tests push expected Tx bytes, grants and responses; a monitor pops and compares.
module tb_axis_spi_reg_arbiter;
   localparam int TIMEOUT = 16;
   localparam int GAP     = 4;

   logic aclk    = 1'b0;
   logic aresetn = 1'b1;
   always #5 aclk = ~aclk;

   axis_spi_reg_arbiter_if bus();

   axis_spi_reg_arbiter #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   typedef struct packed { logic id; logic [7:0] rdata; logic err; } rsp_t;

   logic [7:0] exp_tx[$];
   rsp_t       exp_rsp[$];
   logic       exp_gnt[$];
   int checks = 0, errors = 0, cyc = 0;
   int rdy_cyc = 0, tx_cyc = 0, rsp_cyc = 0;
   bit rsp_seen = 1'b0, bp = 1'b0;
   logic [7:0] rx_bytes[3];
   int withhold = -1, tx_cnt = 0, rx_idx = 0, rx_wait = 0;
   bit rx_pend = 1'b0;
   logic prev_stall = 1'b0, prev_busy = 1'b0;
   logic [7:0] prev_tdata = 8'h00;
   rsp_t e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h expected=none", name, act);
   endtask

   function automatic logic [63:0] outs();
      return {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp0_rdata, bus.rsp0_err,
              bus.rsp1_valid, bus.rsp1_rdata, bus.rsp1_err, bus.m_axis_tvalid, bus.m_axis_tdata,
              bus.s_axis_tready, bus.busy};
   endfunction

   always @(posedge aclk) cyc <= cyc + 1;

   // SPI master model: Rx echo after each Tx handshake, optional delays, withholding, Tx backpressure.
   initial begin
      bus.m_axis_tready = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = 8'h00;
      forever begin
         @(negedge aclk);
         if (aresetn) begin
            rx_pend = 1'b0;
            bus.s_axis_tvalid = 1'b0;
            bus.m_axis_tready = 1'b0;
         end else begin
            if (rx_pend && rx_wait > 0) begin
               rx_wait--;
               bus.s_axis_tvalid = 1'b0;
            end else if (rx_pend && rx_idx == withhold) begin
               rx_pend = 1'b0;
               bus.s_axis_tvalid = 1'b0;
            end else if (rx_pend) begin
               bus.s_axis_tvalid = 1'b1;
               bus.s_axis_tdata  = rx_bytes[rx_idx];
               if (bus.s_axis_tready) begin
                  rx_pend = 1'b0;
                  rx_idx  = (rx_idx == 2) ? 0 : rx_idx + 1;
               end
            end else begin
               bus.s_axis_tvalid = 1'b0;
            end
            bus.m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
               rx_pend = 1'b1;
               rx_wait = bp ? int'($urandom_range(0, 3)) : 0;
               tx_cnt++;
            end
         end
      end
   end

   // Monitor: compares every DUT presentation against the scoreboard queues.
   always begin
      @(negedge aclk);
      #1;
      if (!aresetn) begin
         if (prev_stall)
            check("tdata_stable", {bus.m_axis_tvalid, bus.m_axis_tdata}, {1'b1, prev_tdata});
         prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
         prev_tdata = bus.m_axis_tdata;
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            tx_cyc = cyc;
            if (exp_tx.size() == 0) fail_now("tx_unexpected", bus.m_axis_tdata);
            else check("tx_byte", bus.m_axis_tdata, exp_tx.pop_front());
         end
         if (bus.req0_ready && bus.req1_ready) begin
            fail_now("double_grant", 2'b11);
         end else if (bus.req0_ready || bus.req1_ready) begin
            rdy_cyc = cyc;
            if (exp_gnt.size() == 0) fail_now("grant_unexpected", bus.req1_ready);
            else check("grant_id", bus.req1_ready, exp_gnt.pop_front());
         end
         if (bus.rsp0_valid || bus.rsp1_valid) begin
            rsp_cyc  = cyc;
            rsp_seen = 1'b1;
            if (exp_rsp.size() == 0) begin
               fail_now("rsp_unexpected", {bus.rsp0_valid, bus.rsp1_valid});
            end else begin
               e = exp_rsp.pop_front();
               check("rsp", {bus.rsp0_valid, bus.rsp1_valid,
                             bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata,
                             bus.rsp1_valid ? bus.rsp1_err   : bus.rsp0_err},
                            {!e.id, e.id, e.rdata, e.err});
               check("rsp_other_idle", bus.rsp1_valid ? {bus.rsp0_rdata, bus.rsp0_err}
                                                      : {bus.rsp1_rdata, bus.rsp1_err}, 9'h000);
               if (e.err) check("timeout_latency", rsp_cyc - tx_cyc, TIMEOUT);
               else if (!bp) check("rsp_latency", rsp_cyc - rdy_cyc, 7);
            end
         end
         if (prev_busy && !bus.busy && rsp_seen) begin
            check("gap_len", cyc - rsp_cyc, GAP + 1);
            rsp_seen = 1'b0;
         end
         prev_busy = bus.busy;
      end else begin
         prev_stall = 1'b0;
         prev_busy  = 1'b0;
         rsp_seen   = 1'b0;
      end
   end

   // Queue expectations: tx is the hand-computed byte list, ntx how many bytes go out.
   task automatic expect_txn(input logic id, input logic [23:0] tx, input int ntx,
                             input logic [7:0] rdata, input logic err, input bit has_rsp);
      for (int i = 0; i < ntx; i++) exp_tx.push_back(tx[23 - 8 * i -: 8]);
      exp_gnt.push_back(id);
      if (has_rsp) exp_rsp.push_back({id, rdata, err});
   endtask

   task automatic prep_rx(input logic [23:0] rx, input int hold);
      rx_bytes[0] = rx[23:16];
      rx_bytes[1] = rx[15:8];
      rx_bytes[2] = rx[7:0];
      withhold = hold;
      rx_idx   = 0;
      tx_cnt   = 0;
   endtask

   task automatic issue(input logic id, input logic rw, input logic [14:0] addr, input logic [7:0] wd);
      bit got = 1'b0;
      @(negedge aclk);
      if (id) begin
         bus.req1_rw = rw; bus.req1_addr = addr; bus.req1_wdata = wd; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_rw = rw; bus.req0_addr = addr; bus.req0_wdata = wd; bus.req0_valid = 1'b1;
      end
      for (int i = 0; i < 200 && !got; i++) begin
         #1;
         got = id ? bus.req1_ready : bus.req0_ready;
         @(negedge aclk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (!got) fail_now("req_accept_timeout", id);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_rsp.size() != 0 || bus.busy) && n < 2000) begin
         @(negedge aclk);
         n++;
      end
      #2;
      check("txn_complete", {n < 2000, exp_tx.size(), exp_gnt.size()}, {1'b1, 32'd0, 32'd0});
   endtask

   initial begin
      int n, g;
      bus.req0_valid = 1'b0; bus.req0_rw = 1'b0; bus.req0_addr = 15'h0000; bus.req0_wdata = 8'h00;
      bus.req1_valid = 1'b0; bus.req1_rw = 1'b0; bus.req1_addr = 15'h0000; bus.req1_wdata = 8'h00;
      prep_rx(24'h000000, -1);
      repeat (3) @(negedge aclk);
      #1 check("reset_outputs", outs(), 64'h0);
      @(negedge aclk) aresetn = 1'b0;

      // Write from requester 0, loopback ignored for writes.
      prep_rx(24'hEEEEEE, -1);
      expect_txn(1'b0, 24'h1234A5, 3, 8'h00, 1'b0, 1'b1);
      issue(1'b0, 1'b0, 15'h1234, 8'hA5);
      wait_done();

      // Read from requester 1.
      prep_rx(24'h1122C3, -1);
      expect_txn(1'b1, 24'hFF0100, 3, 8'hC3, 1'b0, 1'b1);
      issue(1'b1, 1'b1, 15'h7F01, 8'h99);
      wait_done();

      // Both valid for four grants: must alternate 0,1,0,1.
      prep_rx(24'h00003C, -1);
      expect_txn(1'b0, 24'h01025A, 3, 8'h00, 1'b0, 1'b1);
      expect_txn(1'b1, 24'hC00300, 3, 8'h3C, 1'b0, 1'b1);
      expect_txn(1'b0, 24'h01025A, 3, 8'h00, 1'b0, 1'b1);
      expect_txn(1'b1, 24'hC00300, 3, 8'h3C, 1'b0, 1'b1);
      @(negedge aclk);
      bus.req0_rw = 1'b0; bus.req0_addr = 15'h0102; bus.req0_wdata = 8'h5A;
      bus.req1_rw = 1'b1; bus.req1_addr = 15'h4003; bus.req1_wdata = 8'h00;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      n = 0; g = 0;
      while (g < 4 && n < 500) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) g++;
         @(negedge aclk);
         n++;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      check("four_grants", g, 4);
      wait_done();

      // Second Rx byte withheld: timeout, byte2 never sent.
      prep_rx(24'h112233, 1);
      expect_txn(1'b0, 24'h805500, 2, 8'h00, 1'b1, 1'b1);
      issue(1'b0, 1'b1, 15'h0055, 8'h00);
      wait_done();

      // Random backpressure on both streams.
      bp = 1'b1;
      prep_rx(24'h5A5A5A, -1);
      expect_txn(1'b1, 24'h1234A5, 3, 8'h00, 1'b0, 1'b1);
      issue(1'b1, 1'b0, 15'h1234, 8'hA5);
      wait_done();
      prep_rx(24'h1122C3, -1);
      expect_txn(1'b0, 24'hFF0100, 3, 8'hC3, 1'b0, 1'b1);
      issue(1'b0, 1'b1, 15'h7F01, 8'h00);
      wait_done();
      bp = 1'b0;

      // Reset while waiting for the byte1 echo.
      prep_rx(24'h000000, 1);
      expect_txn(1'b0, 24'h234577, 2, 8'h00, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 15'h2345, 8'h77);
      n = 0;
      while (!(tx_cnt == 2 && bus.s_axis_tready) && n < 100) begin
         @(negedge aclk);
         #1;
         n++;
      end
      check("reached_wait_rx1", {tx_cnt == 2, bus.s_axis_tready}, 2'b11);
      @(negedge aclk) aresetn = 1'b1;
      @(negedge aclk);
      #1 check("reset_mid_txn", outs(), 64'h0);
      check("reset_drained", {exp_tx.size(), exp_gnt.size()}, 64'h0);
      @(negedge aclk) aresetn = 1'b0;

      prep_rx(24'h000099, -1);
      expect_txn(1'b0, 24'h801000, 3, 8'h99, 1'b0, 1'b1);
      issue(1'b0, 1'b1, 15'h0010, 8'h00);
      wait_done();

      repeat (3) @(negedge aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=%0d expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
